// File: rtl/cpu_pkg.sv
// Shared decode constants, ALU operation codes and data-memory sizing helper
// for the cpu_exec_core execute/memory slice.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1000,
    ALU_LUI = 4'b1001
  } aluc_e;

  // Word-index width for a power-of-two memory depth (at least one bit).
  function automatic int dmem_idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// 32-bit ALU for cpu_exec_core; signed overflow output present only when
// CPU_ALU_OVF_EN is defined.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_aluc,
`ifdef CPU_ALU_OVF_EN
  output logic        o_ovf,
`endif
  output logic [31:0] o_result,
  output logic        o_zero
);

  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;
  logic        [31:0] w_sum;
  logic        [31:0] w_diff;

  assign w_a_s  = i_a;
  assign w_b_s  = i_b;
  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  always_comb begin
    o_result = 32'd0;
    case (i_aluc)
      ALU_ADD: o_result = w_sum;
      ALU_SUB: o_result = w_diff;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLT: o_result = (w_a_s < w_b_s) ? 32'd1 : 32'd0;
      ALU_SLL: o_result = i_b << i_a[4:0];
      ALU_SRL: o_result = i_b >> i_a[4:0];
      ALU_SRA: o_result = w_b_s >>> i_a[4:0];
      ALU_LUI: o_result = i_b << 16;
      default: o_result = 32'd0;
    endcase
  end

  assign o_zero = (o_result == 32'd0);

`ifdef CPU_ALU_OVF_EN
  function automatic logic add_ovf(input logic [31:0] a, b, s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, b, d);
    return (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

  always_comb begin
    o_ovf = 1'b0;
    if (i_aluc == ALU_ADD)      o_ovf = add_ovf(i_a, i_b, w_sum);
    else if (i_aluc == ALU_SUB) o_ovf = sub_ovf(i_a, i_b, w_diff);
  end
`endif

endmodule

// File: rtl/cpu_exec_core.sv
// Execute/memory slice of the single-cycle MIPS-subset CPU: decode, operand
// select, ALU and data memory. Optional macro: CPU_ALU_OVF_EN (adds ovf).
module cpu_exec_core
  import cpu_pkg::*;
#(
  parameter int DMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] q1,
  input  logic [31:0] q2,
  output logic        jump,
  output logic        branch,
  output logic        wreg,
  output logic [4:0]  wdest,
  output logic [31:0] wdata,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        wmem,
`ifdef CPU_ALU_OVF_EN
  output logic        ovf,
`endif
  output logic [3:0]  aluc
);

  localparam int IDX_W = dmem_idx_w(DMEM_DEPTH);

  logic [5:0]  w_op;
  logic [5:0]  w_func;
  logic [15:0] w_imm;
  logic        w_wreg, w_regrt, w_shift, w_aluimm, w_sext, w_m2reg;
  logic        w_wmem, w_jump, w_beq, w_bne, w_ovf_chk;
  aluc_e       w_aluc;
  logic [31:0] w_a, w_b, w_ext;
  logic [IDX_W-1:0] w_idx;
  logic [31:0] r_mem [DMEM_DEPTH];

  assign w_op   = inst[31:26];
  assign w_func = inst[5:0];
  assign w_imm  = inst[15:0];

  // Unrecognised op/func leave every enable low: a safe NOP.
  always_comb begin
    w_wreg    = 1'b0;
    w_regrt   = 1'b0;
    w_shift   = 1'b0;
    w_aluimm  = 1'b0;
    w_sext    = 1'b0;
    w_m2reg   = 1'b0;
    w_wmem    = 1'b0;
    w_jump    = 1'b0;
    w_beq     = 1'b0;
    w_bne     = 1'b0;
    w_ovf_chk = 1'b0;
    w_aluc    = ALU_ADD;
    case (w_op)
      OP_RTYPE: begin
        case (w_func)
          F_ADD: begin w_wreg = 1'b1; w_aluc = ALU_ADD; w_ovf_chk = 1'b1; end
          F_SUB: begin w_wreg = 1'b1; w_aluc = ALU_SUB; w_ovf_chk = 1'b1; end
          F_AND: begin w_wreg = 1'b1; w_aluc = ALU_AND; end
          F_OR:  begin w_wreg = 1'b1; w_aluc = ALU_OR;  end
          F_XOR: begin w_wreg = 1'b1; w_aluc = ALU_XOR; end
          F_SLT: begin w_wreg = 1'b1; w_aluc = ALU_SLT; end
          F_SLL: begin w_wreg = 1'b1; w_shift = 1'b1; w_aluc = ALU_SLL; end
          F_SRL: begin w_wreg = 1'b1; w_shift = 1'b1; w_aluc = ALU_SRL; end
          F_SRA: begin w_wreg = 1'b1; w_shift = 1'b1; w_aluc = ALU_SRA; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        w_wreg = 1'b1; w_regrt = 1'b1; w_aluimm = 1'b1; w_sext = 1'b1;
        w_aluc = ALU_ADD; w_ovf_chk = 1'b1;
      end
      OP_SLTI: begin
        w_wreg = 1'b1; w_regrt = 1'b1; w_aluimm = 1'b1; w_sext = 1'b1;
        w_aluc = ALU_SLT;
      end
      OP_ANDI: begin w_wreg = 1'b1; w_regrt = 1'b1; w_aluimm = 1'b1; w_aluc = ALU_AND; end
      OP_ORI:  begin w_wreg = 1'b1; w_regrt = 1'b1; w_aluimm = 1'b1; w_aluc = ALU_OR;  end
      OP_XORI: begin w_wreg = 1'b1; w_regrt = 1'b1; w_aluimm = 1'b1; w_aluc = ALU_XOR; end
      OP_LUI:  begin w_wreg = 1'b1; w_regrt = 1'b1; w_aluimm = 1'b1; w_aluc = ALU_LUI; end
      OP_LW: begin
        w_wreg = 1'b1; w_regrt = 1'b1; w_aluimm = 1'b1; w_sext = 1'b1;
        w_m2reg = 1'b1; w_aluc = ALU_ADD;
      end
      OP_SW:  begin w_wmem = 1'b1; w_aluimm = 1'b1; w_sext = 1'b1; w_aluc = ALU_ADD; end
      OP_BEQ: begin w_beq = 1'b1; w_aluc = ALU_SUB; end
      OP_BNE: begin w_bne = 1'b1; w_aluc = ALU_SUB; end
      OP_J:   w_jump = 1'b1;
      default: ;
    endcase
  end

  assign w_ext = w_sext ? {{16{w_imm[15]}}, w_imm} : {16'd0, w_imm};
  assign w_a   = w_shift  ? {27'd0, inst[10:6]} : q1;
  assign w_b   = w_aluimm ? w_ext : q2;

`ifdef CPU_ALU_OVF_EN
  logic w_alu_ovf;

  cpu_alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_aluc   (w_aluc),
    .o_ovf    (w_alu_ovf),
    .o_result (alu_result),
    .o_zero   (zero)
  );

  // Overflowing add/sub/addi must leave the destination untouched.
  assign ovf  = w_ovf_chk & w_alu_ovf;
  assign wreg = w_wreg & ~ovf;
  logic w_unused;
  assign w_unused = ^inst[25:21];
`else
  cpu_alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_aluc   (w_aluc),
    .o_result (alu_result),
    .o_zero   (zero)
  );

  assign wreg = w_wreg;
  logic w_unused;
  assign w_unused = ^{inst[25:21], w_ovf_chk};
`endif

  assign aluc   = w_aluc;
  assign jump   = w_jump;
  assign wmem   = w_wmem;
  assign branch = (w_beq & zero) | (w_bne & ~zero);
  assign wdest  = w_regrt ? inst[20:16] : inst[15:11];

  // Byte address; low two bits and bits above the depth are dropped (wrap).
  assign w_idx = alu_result[IDX_W+1:2];
  assign wdata = w_m2reg ? r_mem[w_idx] : alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_wmem) begin
      r_mem[w_idx] <= q2;
    end
  end

endmodule

// File: tb/tb_cpu_exec_core.sv
// Directed self-checking bench for cpu_exec_core (ovf checks when
// CPU_ALU_OVF_EN is defined).
module tb_cpu_exec_core;

  logic        clk;
  logic        rst;
  logic [31:0] inst, q1, q2;
  logic        jump, branch, wreg, zero, wmem;
  logic [4:0]  wdest;
  logic [31:0] wdata, alu_result;
  logic [3:0]  aluc;
`ifdef CPU_ALU_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;

  cpu_exec_core #(.DMEM_DEPTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .q1         (q1),
    .q2         (q2),
    .jump       (jump),
    .branch     (branch),
    .wreg       (wreg),
    .wdest      (wdest),
    .wdata      (wdata),
    .alu_result (alu_result),
    .zero       (zero),
    .wmem       (wmem),
`ifdef CPU_ALU_OVF_EN
    .ovf        (ovf),
`endif
    .aluc       (aluc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    inst = i;
    q1   = a;
    q2   = b;
    #1;
  endtask

  initial begin
    rst = 1'b0; inst = 32'd0; q1 = 32'd0; q2 = 32'd0;
    #1 rst = 1'b1;
    drive(32'h8C000000, 32'd0, 32'd0);
    chk("reset_lw0_wdata", wdata, 32'd0);
    chk("reset_lw0_wmem", {31'd0, wmem}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    drive(32'h00010820, 32'd5, 32'd7);
    chk("add_aluc", {28'd0, aluc}, 32'h0);
    chk("add_result", alu_result, 32'd12);
    chk("add_wreg", {31'd0, wreg}, 32'd1);
    chk("add_wdest", {27'd0, wdest}, 32'd1);
    chk("add_wdata", wdata, 32'd12);
    chk("add_zero", {31'd0, zero}, 32'd0);

    drive(32'h00010822, 32'd5, 32'd7);
    chk("sub_result", alu_result, 32'hFFFFFFFE);
    chk("sub_aluc", {28'd0, aluc}, 32'h1);
    drive(32'h0001082A, 32'hFFFFFFFF, 32'd1);
    chk("slt_signed", alu_result, 32'd1);

    drive(32'h20210FFF, 32'd1, 32'd0);
    chk("addi_result", alu_result, 32'h00001000);
    chk("addi_wdest", {27'd0, wdest}, 32'd1);
    drive(32'h2021FFFF, 32'd1, 32'd0);
    chk("addi_neg_zero", {31'd0, zero}, 32'd1);
    drive(32'h34218015, 32'd0, 32'd0);
    chk("ori_zext", alu_result, 32'h00008015);
    drive(32'h28218000, 32'd0, 32'd0);
    chk("slti_sext", alu_result, 32'd0);
    drive(32'h3C011234, 32'd0, 32'd0);
    chk("lui_result", alu_result, 32'h12340000);

    @(negedge clk);
    drive(32'hAC010004, 32'd0, 32'hDEADBEEF);
    chk("sw_wmem", {31'd0, wmem}, 32'd1);
    chk("sw_wreg", {31'd0, wreg}, 32'd0);
    chk("sw_addr", alu_result, 32'd4);
    @(posedge clk);
    #1;
    drive(32'h8C010004, 32'd0, 32'd0);
    chk("lw_wdata", wdata, 32'hDEADBEEF);
    chk("lw_wreg", {31'd0, wreg}, 32'd1);
    chk("lw_wmem", {31'd0, wmem}, 32'd0);
    drive(32'h8C010004, 32'd128, 32'd0);
    chk("lw_wrap", wdata, 32'hDEADBEEF);

    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    drive(32'h8C010004, 32'd0, 32'd0);
    chk("rst_clears", wdata, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    drive(32'hAC010004, 32'd0, 32'h12345678);
    @(posedge clk);
    #1;
    drive(32'h8C010004, 32'd0, 32'd0);
    rst = 1'b0;
    #1;
    chk("sw_blocked_by_rst", wdata, 32'd0);

    drive(32'h10220000, 32'd3, 32'd3);
    chk("beq_branch", {31'd0, branch}, 32'd1);
    chk("beq_zero", {31'd0, zero}, 32'd1);
    chk("beq_wreg", {31'd0, wreg}, 32'd0);
    drive(32'h14220000, 32'd3, 32'd3);
    chk("bne_equal", {31'd0, branch}, 32'd0);
    drive(32'h14220000, 32'd3, 32'd4);
    chk("bne_diff", {31'd0, branch}, 32'd1);
    drive(32'h08000000, 32'd0, 32'd0);
    chk("j_jump", {31'd0, jump}, 32'd1);
    chk("j_wreg", {31'd0, wreg}, 32'd0);

    drive(32'h00021903, 32'd0, 32'h80000000);
    chk("sra_result", alu_result, 32'hF8000000);
    chk("sra_wdest", {27'd0, wdest}, 32'd3);
    drive(32'h00021902, 32'd0, 32'h80000000);
    chk("srl_result", alu_result, 32'h08000000);
    drive(32'h00000000, 32'd9, 32'h00000055);
    chk("nop_sll_result", alu_result, 32'h00000055);
    chk("nop_sll_wreg", {31'd0, wreg}, 32'd1);

    drive(32'hFC000000, 32'd1, 32'd1);
    chk("unk_op_enables", {27'd0, wreg, wmem, jump, branch, 1'b0}, 32'd0);
    chk("unk_op_aluc", {28'd0, aluc}, 32'h0);
    drive(32'h0000003F, 32'd1, 32'd1);
    chk("unk_func_enables", {28'd0, wreg, wmem, jump, branch}, 32'd0);

`ifdef CPU_ALU_OVF_EN
    drive(32'h00010820, 32'h7FFFFFFF, 32'd1);
    chk("ovf_add", {31'd0, ovf}, 32'd1);
    chk("ovf_wreg", {31'd0, wreg}, 32'd0);
    drive(32'h00010820, 32'd5, 32'd7);
    chk("no_ovf_add", {31'd0, ovf}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
